// File: rtl/fp_round_pack.sv
// Rounds a {sign, exp, sig, round bit} sample half-up and packs it into an 8-bit float {S,E[2:0],F[3:0]}.
// Latency: 2 cycles from accept to out_valid (S1 register, then the 2-entry output FIFO).
// Backpressure: holds up to 3 samples (S1 + 2 FIFO entries); in_ready follows out_ready combinationally.
//
// Ports: clk/rst (async, active-high); in_valid/in_ready with in_sign, in_exp, in_sig, in_fifth;
//        out_valid/out_ready with out_data; round_cnt and sat_cnt are wrapping event counters.
`timescale 1ns/1ps
module fp_round_pack (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic       in_sign,
   input  logic [2:0] in_exp,
   input  logic [3:0] in_sig,
   input  logic       in_fifth,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_data,
   output logic [7:0] round_cnt,
   output logic [7:0] sat_cnt
);

   logic       s1_v;
   logic       s1_sign;
   logic [2:0] s1_exp;
   logic [3:0] s1_sig;
   logic       s1_fifth;

   logic [7:0] fifo_mem [2];
   logic       wr_ptr;
   logic       rd_ptr;
   logic [1:0] fifo_cnt;

   logic       pop;
   logic       s1_adv;
   logic       accept;

   logic [2:0] rnd_exp;
   logic [3:0] rnd_sig;
   logic       rnd_inc;
   logic       rnd_sat;

   assign out_valid = (fifo_cnt != 2'd0);
   assign pop       = out_valid && out_ready;
   // A full FIFO still takes the S1 result when its head is being consumed this cycle.
   assign s1_adv    = s1_v && ((fifo_cnt < 2'd2) || pop);
   assign in_ready  = !s1_v || s1_adv;
   assign accept    = in_valid && in_ready;
   assign out_data  = fifo_mem[rd_ptr];

   // Round-half-up. A carry out of the significand renormalises to 1.000 with exp+1;
   // at the largest exponent the value clamps to the format maximum instead.
   always_comb begin
      rnd_exp = s1_exp;
      rnd_sig = s1_sig;
      rnd_inc = 1'b0;
      rnd_sat = 1'b0;
      if (s1_fifth) begin
         if (s1_sig != 4'b1111) begin
            rnd_sig = s1_sig + 4'd1;
            rnd_inc = 1'b1;
         end else if (s1_exp != 3'd7) begin
            rnd_exp = s1_exp + 3'd1;
            rnd_sig = 4'b1000;
            rnd_inc = 1'b1;
         end else begin
            rnd_sat = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_v     <= 1'b0;
         s1_sign  <= 1'b0;
         s1_exp   <= 3'd0;
         s1_sig   <= 4'd0;
         s1_fifth <= 1'b0;
      end else begin
         if (accept) begin
            s1_v     <= 1'b1;
            s1_sign  <= in_sign;
            s1_exp   <= in_exp;
            s1_sig   <= in_sig;
            s1_fifth <= in_fifth;
         end else if (s1_adv) begin
            s1_v     <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fifo_mem[0] <= 8'h00;
         fifo_mem[1] <= 8'h00;
         wr_ptr      <= 1'b0;
         rd_ptr      <= 1'b0;
         fifo_cnt    <= 2'd0;
      end else begin
         if (s1_adv) begin
            fifo_mem[wr_ptr] <= {s1_sign, rnd_exp, rnd_sig};
            wr_ptr           <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({s1_adv, pop})
            2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
            2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

   // Counters tick on the cycle the rounded result enters the FIFO.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         round_cnt <= 8'd0;
         sat_cnt   <= 8'd0;
      end else if (s1_adv) begin
         if (rnd_inc) begin
            round_cnt <= round_cnt + 8'd1;
         end
         if (rnd_sat) begin
            sat_cnt <= sat_cnt + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_fp_round_pack.sv
`timescale 1ns/1ps
module tb_fp_round_pack;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic       in_sign;
   logic [2:0] in_exp;
   logic [3:0] in_sig;
   logic       in_fifth;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic [7:0] round_cnt;
   logic [7:0] sat_cnt;

   int checks = 0;
   int errors = 0;
   logic [7:0] sb [$];

   always #5 clk = ~clk;

   fp_round_pack dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_sign(in_sign), .in_exp(in_exp), .in_sig(in_sig), .in_fifth(in_fifth),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .round_cnt(round_cnt), .sat_cnt(sat_cnt)
   );

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   // Monitor: every handshake on the output pops and compares the scoreboard head.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL out_data: unexpected output %h, scoreboard empty", out_data);
         end else begin
            logic [7:0] exp_v;
            exp_v = sb.pop_front();
            if (out_data !== exp_v) begin
               errors++;
               $display("FAIL out_data: got %h, expected %h", out_data, exp_v);
            end
         end
      end
   end

   // Presents a sample and returns one cycle after it is accepted; in_valid is left high.
   task automatic send(input logic s, input logic [2:0] e, input logic [3:0] f,
                       input logic b, input logic [7:0] exp_out);
      bit done = 0;
      in_valid = 1'b1;
      in_sign  = s;
      in_exp   = e;
      in_sig   = f;
      in_fifth = b;
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge clk);
         if (in_ready) begin
            sb.push_back(exp_out);
            done = 1;
         end
         @(posedge clk);
         #1;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL accept: sample %h never accepted, expected acceptance", {s, e, f});
      end
   endtask

   task automatic idle();
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(posedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d outputs missing, expected 0", sb.size());
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_exp = 3'd0; in_sig = 4'd0;
      in_fifth = 1'b0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", {7'd0, out_valid}, 8'h00);
      check("rst_in_ready",  {7'd0, in_ready},  8'h01);
      check("rst_out_data",  out_data,  8'h00);
      check("rst_round_cnt", round_cnt, 8'h00);
      check("rst_sat_cnt",   sat_cnt,   8'h00);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Basic rounding, renormalise, saturate.
      send(1'b0, 3'd3, 4'b1010, 1'b1, 8'h3B); idle(); drain();
      check("round_cnt_a", round_cnt, 8'd1);
      send(1'b0, 3'd3, 4'b1010, 1'b0, 8'h3A); idle(); drain();
      check("round_cnt_b", round_cnt, 8'd1);
      send(1'b0, 3'd3, 4'b1111, 1'b1, 8'h48); idle(); drain();
      check("round_cnt_renorm", round_cnt, 8'd2);
      send(1'b1, 3'd7, 4'b1111, 1'b1, 8'hFF); idle(); drain();
      check("sat_cnt_a",   sat_cnt,   8'd1);
      check("round_cnt_c", round_cnt, 8'd2);

      // Back-to-back stream at full throughput.
      send(1'b0, 3'd2, 4'b0111, 1'b1, 8'h28);
      send(1'b1, 3'd5, 4'b0011, 1'b0, 8'hD3);
      send(1'b1, 3'd6, 4'b1111, 1'b1, 8'hF8);
      send(1'b0, 3'd7, 4'b1111, 1'b1, 8'h7F);
      idle(); drain();
      check("round_cnt_stream", round_cnt, 8'd4);
      check("sat_cnt_stream",   sat_cnt,   8'd2);

      // Back-pressure: three held, fourth stalls until out_ready rises.
      out_ready = 1'b0;
      send(1'b0, 3'd1, 4'h0, 1'b0, 8'h10);
      send(1'b0, 3'd2, 4'h1, 1'b0, 8'h21);
      send(1'b0, 3'd3, 4'h2, 1'b0, 8'h32);
      fork
         send(1'b0, 3'd4, 4'h3, 1'b0, 8'h43);
         begin
            repeat (3) @(posedge clk);
            #2;
            check("bp_in_ready_low", {7'd0, in_ready},  8'h00);
            check("bp_out_valid",    {7'd0, out_valid}, 8'h01);
            check("bp_head_stable",  out_data, 8'h10);
            out_ready = 1'b1;
            #1;
            check("bp_in_ready_rise", {7'd0, in_ready}, 8'h01);
         end
      join
      idle(); drain();
      check("round_cnt_bp", round_cnt, 8'd4);

      // Reset with S1 and both FIFO entries occupied.
      out_ready = 1'b0;
      send(1'b0, 3'd1, 4'h0, 1'b1, 8'h11);
      send(1'b0, 3'd2, 4'h0, 1'b1, 8'h21);
      send(1'b0, 3'd3, 4'h0, 1'b1, 8'h31);
      idle();
      check("mid_in_ready_full", {7'd0, in_ready}, 8'h00);
      check("mid_round_cnt_pre", round_cnt, 8'd6);
      #2;
      rst = 1'b1;
      sb.delete();
      #1;
      check("mid_out_valid", {7'd0, out_valid}, 8'h00);
      check("mid_round_cnt", round_cnt, 8'h00);
      check("mid_sat_cnt",   sat_cnt,   8'h00);
      check("mid_in_ready",  {7'd0, in_ready}, 8'h01);
      @(posedge clk);
      #1;
      rst = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      send(1'b0, 3'd1, 4'b0001, 1'b1, 8'h12); idle(); drain();
      check("post_rst_round_cnt", round_cnt, 8'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
